mips_fact_periph: RTL and testbench
===================================

# mips_fact_periph

Memory-mapped factorial accelerator that answers the bus address decoder's peripheral-1 window (0x0000_0800–0x0000_08FF). Responds to decoded write-enable `we1` with register writes. Returns read data for `rdsel = 2'b10` through the read mux. Computes n! iteratively, one multiply per cycle, and exposes busy/done/error status to polling software.

## Interface
Parameters:
- `DATA_W`, 32, width of bus data and result register
- `N_W`, 4, width of the operand register n
- `MAX_N`, 12, largest n whose factorial fits in `DATA_W` bits

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low
- `a`  in  2  word offset, bus address bits [3:2]
- `we`  in  1  decoded write strobe (driven by `we1` from the address decoder)
- `wd`  in  DATA_W  write data
- `rd`  out  DATA_W  combinational read data for the addressed register

## Operation
Register map (offset `a`):
- 0 N: R/W. Writes take `wd[N_W-1:0]`. Reads return zero-extended n.
- 1 GO: W. A write with `wd[0]=1` starts a computation. Reads return `{31'b0, busy}`.
- 2 STATUS: R. Reads return `{29'b0, busy, err, done}`. Writes are ignored.
- 3 RESULT: R. Reads return the product when `done & ~err`, and 0 otherwise. Writes are ignored.

FSM states:
- IDLE → BUSY on a valid GO write with n ≤ MAX_N. The same edge loads product=1 and cnt=n, and clears done and err.
- IDLE or DONE → DONE on a GO write with n > MAX_N. The same edge sets err=1 and done=1, and product stays 0.
- BUSY, while cnt > 1: product ← product·cnt (low DATA_W bits), cnt ← cnt−1.
- BUSY → DONE when cnt ≤ 1; the same edge sets done=1. This covers n=0 and n=1, giving result 1.
- DONE → BUSY or DONE on a GO write, using the same rules as IDLE.

Busy rules:
- busy = (state == BUSY).
- While busy, writes to N and GO writes are ignored, and no register changes.
- done and err are sticky until the next accepted GO write.

Other rules:
- A GO write with `wd[0]=0` has no effect.
- Writes only occur when `we=1`. `a` is don't-care when `we=0`, but `rd` still follows `a`.

## Timing
- Reset values: state=IDLE, n=0, cnt=0, product=0, done=0, err=0. As a result, `rd` reads 0 at every offset, and GO/STATUS read busy=0.
- Reset has priority over a simultaneous write on the same edge.
- Reset asserted mid-computation aborts the computation, with no result retained.
- Latency: a GO accepted at edge k sets done=1 at edge k+max(n,1). Examples:
  - n=5: done at k+5, product=120.
  - n=0: done at k+1, product=1.
  - n > MAX_N: done=1 and err=1 at edge k itself.
- `rd` is purely combinational from `a` and registered state. A read issued the cycle after a write sees the new value.
- A write to N and a GO in the same cycle is impossible (single port). A GO therefore uses the N value latched at an earlier edge.

## Structure
- Shared package `mips_periph_pkg` holds:
  - Offset constants `FACT_N_OFF=2'd0`, `FACT_GO_OFF=2'd1`, `FACT_ST_OFF=2'd2`, `FACT_RES_OFF=2'd3`
  - State enum `fact_state_e {FACT_IDLE, FACT_BUSY, FACT_DONE}`
  - `FACT_MAX_N`
- One sub-module, `mips_fact_core`, owns the FSM, cnt and product. Its interface is start/n in, and busy/done/err/product out.
- The top module holds the N register, write decode and read mux.

## Test plan
- Reset then read all four offsets → all return 0; STATUS=0.
- Write N=5, GO=1; poll STATUS → busy=1 for 5 cycles, then STATUS=3'b001 at edge k+5; RESULT=120.
- N=0 and N=1 → done at edge k+1, RESULT=1. N=12 → RESULT=479001600 (0x1C8CFC00) at edge k+12.
- N=13, GO → STATUS=3'b011 at edge k; RESULT=0. A following N=3, GO → err clears, RESULT=6.
- During N=10 busy: write N=2 and GO → both ignored; RESULT=3628800, and N reads 10.
- `rst_n`=0 at cycle 3 of an N=8 run → next cycle STATUS=0 and RESULT=0. A new GO computes 40320.

Source files
------------

// File: rtl/mips_periph_pkg.sv
// Shared constants and types for the memory-mapped peripherals on the MIPS bus.
package mips_periph_pkg;

    localparam logic [1:0] FACT_N_OFF   = 2'd0;
    localparam logic [1:0] FACT_GO_OFF  = 2'd1;
    localparam logic [1:0] FACT_ST_OFF  = 2'd2;
    localparam logic [1:0] FACT_RES_OFF = 2'd3;

    localparam int FACT_MAX_N = 12;

    typedef enum logic [1:0] {
        FACT_IDLE,
        FACT_BUSY,
        FACT_DONE
    } fact_state_e;

endpackage

// File: rtl/mips_fact_core.sv
// Iterative factorial engine: one multiply per cycle, sticky done/err flags.
//   state     | meaning
//   FACT_IDLE | out of reset, nothing computed yet
//   FACT_BUSY | multiplying product by cnt, counting cnt down
//   FACT_DONE | result (or error) held until the next accepted start
module mips_fact_core
    import mips_periph_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = FACT_MAX_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [N_W-1:0]    n_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [DATA_W-1:0] product_o
);

    localparam logic [N_W-1:0]    MAX_N_L = N_W'(MAX_N);
    localparam logic [N_W-1:0]    CNT_ONE = N_W'(1);
    localparam logic [DATA_W-1:0] PROD_ONE = DATA_W'(1);

    fact_state_e       state_q, state_d;
    logic [N_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] product_q, product_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FACT_IDLE;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = done_q;
        err_d     = err_q;
        case (state_q)
            FACT_BUSY: begin
                if (cnt_q > CNT_ONE) begin
                    product_d = product_q * DATA_W'(cnt_q);
                    cnt_d     = cnt_q - CNT_ONE;
                end else begin
                    state_d = FACT_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (start_i) begin
                    if (n_i > MAX_N_L) begin
                        // Overflowing operand: report immediately, never expose a partial product
                        state_d   = FACT_DONE;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        product_d = '0;
                    end else begin
                        state_d   = FACT_BUSY;
                        cnt_d     = n_i;
                        product_d = PROD_ONE;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                    end
                end
            end
        endcase
    end

    assign busy_o    = (state_q == FACT_BUSY);
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign product_o = product_q;

endmodule

// File: rtl/mips_fact_periph.sv
// Factorial peripheral: N register, bus write decode and combinational read mux.
module mips_fact_periph
    import mips_periph_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_W    = 4,
    parameter int MAX_N  = FACT_MAX_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        a,
    input  logic              we,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    logic [N_W-1:0]    n_q, n_d;
    logic              busy, done, err, start;
    logic [DATA_W-1:0] product;
    logic              unused_wd;

    assign unused_wd = ^wd[DATA_W-1:N_W];

    assign start = we && (a == FACT_GO_OFF) && wd[0] && !busy;

    always_comb begin
        n_d = n_q;
        if (we && (a == FACT_N_OFF) && !busy) begin
            n_d = wd[N_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q <= '0;
        end else begin
            n_q <= n_d;
        end
    end

    mips_fact_core #(
        .DATA_W (DATA_W),
        .N_W    (N_W),
        .MAX_N  (MAX_N)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .n_i       (n_q),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .product_o (product)
    );

    always_comb begin
        rd = '0;
        case (a)
            FACT_N_OFF:  rd = DATA_W'(n_q);
            FACT_GO_OFF: rd = {{(DATA_W-1){1'b0}}, busy};
            FACT_ST_OFF: rd = {{(DATA_W-3){1'b0}}, busy, err, done};
            default:     rd = (done && !err) ? product : '0;
        endcase
    end

endmodule

// File: tb/tb_mips_fact_periph.sv
// Self-checking bench for mips_fact_periph: directed vectors plus a randomized run against a latency/result model.
module tb_mips_fact_periph;
    import mips_periph_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  a = 2'd0;
    logic        we = 1'b0;
    logic [31:0] wd = 32'd0;
    logic [31:0] rd;

    int checks = 0;
    int failures = 0;

    mips_fact_periph dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .we    (we),
        .wd    (wd),
        .rd    (rd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] fact(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= n; i++) p = p * 32'(i);
        return p;
    endfunction

    // Reference: an accepted GO schedules done max(n,1) edges later with result n!.
    logic [3:0]  m_n = 4'd0;
    int          m_rem = 0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_res = 32'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n = 4'd0; m_rem = 0; m_done = 1'b0; m_err = 1'b0; m_res = 32'd0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_done = 1'b1;
        end else if (we) begin
            if (a == FACT_N_OFF) begin
                m_n = wd[3:0];
            end else if (a == FACT_GO_OFF && wd[0]) begin
                if (int'(m_n) > FACT_MAX_N) begin
                    m_err = 1'b1; m_done = 1'b1; m_res = 32'd0;
                end else begin
                    m_rem  = (m_n == 4'd0) ? 1 : int'(m_n);
                    m_done = 1'b0;
                    m_err  = 1'b0;
                    m_res  = fact(int'(m_n));
                end
            end
        end
    end

    function automatic logic [31:0] m_expect(input logic [1:0] off);
        logic b;
        b = (m_rem > 0);
        case (off)
            FACT_N_OFF:  return {28'd0, m_n};
            FACT_GO_OFF: return {31'd0, b};
            FACT_ST_OFF: return {29'd0, b, m_err, m_done};
            default:     return (m_done && !m_err) ? m_res : 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_at(input logic [1:0] off, output logic [31:0] v);
        a = off;
        #1;
        v = rd;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        a  = off;
        wd = d;
        we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [1:0] off, input logic [31:0] exp);
        logic [31:0] v;
        rd_at(off, v);
        chk(name, v, exp);
    endtask

    task automatic chk_model(input string name);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            rd_at(2'(i), v);
            chk($sformatf("%s_off%0d", name, i), v, m_expect(2'(i)));
        end
    endtask

    task automatic wait_done(input string name);
        logic [31:0] v;
        logic        seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            rd_at(FACT_ST_OFF, v);
            if (v[0]) seen = 1'b1;
            else step();
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  n;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] v;
        int          r;

        vecs[0] = '{4'd0,  32'd1,         1};
        vecs[1] = '{4'd1,  32'd1,         1};
        vecs[2] = '{4'd5,  32'd120,       5};
        vecs[3] = '{4'd12, 32'h1C8C_FC00, 12};
        vecs[4] = '{4'd3,  32'd6,         3};
        vecs[5] = '{4'd7,  32'd5040,      7};
        vecs[6] = '{4'd2,  32'd2,         2};

        step();
        step();
        rst_n = 1'b1;
        chk_rd("reset_n",      FACT_N_OFF,   32'd0);
        chk_rd("reset_go",     FACT_GO_OFF,  32'd0);
        chk_rd("reset_status", FACT_ST_OFF,  32'd0);
        chk_rd("reset_result", FACT_RES_OFF, 32'd0);

        rst_n = 1'b0;
        wr(FACT_N_OFF, 32'd7);
        rst_n = 1'b1;
        chk_rd("reset_beats_write", FACT_N_OFF, 32'd0);
        wr(FACT_N_OFF, 32'hFFFF_FFF7);
        chk_rd("n_write_low_bits", FACT_N_OFF, 32'd7);

        for (int t = 0; t < 7; t++) begin
            wr(FACT_N_OFF, {28'd0, vecs[t].n});
            chk_rd($sformatf("vec%0d_n", t), FACT_N_OFF, {28'd0, vecs[t].n});
            wr(FACT_GO_OFF, 32'd1);
            for (int c = 0; c < vecs[t].lat; c++) begin
                chk_rd($sformatf("vec%0d_busy_c%0d", t, c), FACT_ST_OFF, 32'd4);
                if (c == 0) chk_rd($sformatf("vec%0d_go_rd", t), FACT_GO_OFF, 32'd1);
                step();
            end
            chk_rd($sformatf("vec%0d_status", t), FACT_ST_OFF, 32'd1);
            chk_rd($sformatf("vec%0d_result", t), FACT_RES_OFF, vecs[t].res);
        end

        wr(FACT_N_OFF, 32'd13);
        wr(FACT_GO_OFF, 32'd1);
        chk_rd("err_status", FACT_ST_OFF, 32'd3);
        chk_rd("err_result", FACT_RES_OFF, 32'd0);
        step();
        chk_rd("err_sticky", FACT_ST_OFF, 32'd3);
        wr(FACT_N_OFF, 32'd3);
        wr(FACT_GO_OFF, 32'd1);
        chk_rd("err_clear_busy", FACT_ST_OFF, 32'd4);
        wait_done("err_recover_done");
        chk_rd("err_recover_result", FACT_RES_OFF, 32'd6);
        wr(FACT_GO_OFF, 32'd2);
        chk_rd("go_bit0_zero", FACT_ST_OFF, 32'd1);
        wr(FACT_ST_OFF, 32'hFFFF_FFFF);
        wr(FACT_RES_OFF, 32'h0);
        chk_rd("ro_status", FACT_ST_OFF, 32'd1);
        chk_rd("ro_result", FACT_RES_OFF, 32'd6);

        wr(FACT_N_OFF, 32'd10);
        wr(FACT_GO_OFF, 32'd1);
        wr(FACT_N_OFF, 32'd2);
        wr(FACT_GO_OFF, 32'd1);
        wait_done("busy_ign_done");
        chk_rd("busy_ign_result", FACT_RES_OFF, 32'd3628800);
        chk_rd("busy_ign_n", FACT_N_OFF, 32'd10);

        wr(FACT_N_OFF, 32'd8);
        wr(FACT_GO_OFF, 32'd1);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_rd("abort_status", FACT_ST_OFF, 32'd0);
        chk_rd("abort_result", FACT_RES_OFF, 32'd0);
        chk_rd("abort_n", FACT_N_OFF, 32'd0);
        wr(FACT_N_OFF, 32'd8);
        wr(FACT_GO_OFF, 32'd1);
        wait_done("abort_rerun_done");
        chk_rd("abort_rerun_result", FACT_RES_OFF, 32'd40320);

        chk_model("model_sync");
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 19));
            if (r < 4)       wr(FACT_N_OFF, $urandom);
            else if (r < 7)  wr(FACT_GO_OFF, $urandom);
            else if (r < 8)  wr(2'(2 + $urandom_range(0, 1)), $urandom);
            else if (r == 8) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else step();
            chk_model($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
